// File: rtl/vga_pkg.sv
// Shared constants and types for the VGA scan-out stage: default 640x480@60
// geometry, counter width, and the per-pixel control word that travels
// alongside the memory request.
package vga_pkg;

  localparam int CNT_W = 10;

  localparam int H_TOTAL      = 640 + 16 + 96 + 48;
  localparam int V_TOTAL      = 480 + 10 + 2 + 33;
  localparam int H_SYNC_START = 640 + 16;
  localparam int H_SYNC_END   = 640 + 16 + 96;
  localparam int V_SYNC_START = 480 + 10;
  localparam int V_SYNC_END   = 480 + 10 + 2;

  typedef struct packed {
    logic visible;
    logic in_window;
    logic hsync_n;
    logic vsync_n;
    logic first;
  } scan_ctrl_t;

  // Blanked, sync-inactive control word used for reset and pipeline clear.
  localparam scan_ctrl_t SCAN_IDLE = '{visible: 1'b0, in_window: 1'b0,
                                       hsync_n: 1'b1, vsync_n: 1'b1,
                                       first: 1'b0};

  // Half-open interval test lo <= value < hi on counter-width values.
  function automatic logic in_range(input logic [CNT_W-1:0] value,
                                    input logic [CNT_W-1:0] lo,
                                    input logic [CNT_W-1:0] hi);
    return (value >= lo) && (value < hi);
  endfunction

endpackage

// File: rtl/vga_controller_scan_delay.sv
// Depth-N shift register of scan control words. Holds the sync/blank/window
// flags back while the memory fetches the pixel so they reach the output
// stage together with the returned data. DEPTH must be at least 1.
module scan_delay
  import vga_pkg::*;
#(
  parameter int DEPTH = 1
) (
  input  logic       clk,
  input  logic       clr,
  input  scan_ctrl_t din,
  output scan_ctrl_t dout
);

  scan_ctrl_t stage_r [DEPTH];

  // Shift control words one stage per cycle; clear to the idle word.
  always_ff @(posedge clk) begin
    if (clr) begin
      for (int i = 0; i < DEPTH; i++) begin
        stage_r[i] <= SCAN_IDLE;
      end
    end else begin
      stage_r[0] <= din;
      for (int i = 1; i < DEPTH; i++) begin
        stage_r[i] <= stage_r[i-1];
      end
    end
  end

  assign dout = stage_r[DEPTH-1];

endmodule

// File: rtl/vga_controller.sv
// VGA scan-out: timing counters, image-window address generation into the
// GPU read port, and grayscale-to-RGB output aligned with the syncs.
// Latency from counter value to outputs is 2 + MEM_LATENCY cycles.
module vga_controller
  import vga_pkg::*;
#(
  parameter int H_VISIBLE   = 640,
  parameter int H_FRONT     = 16,
  parameter int H_SYNC      = 96,
  parameter int H_BACK      = 48,
  parameter int V_VISIBLE   = 480,
  parameter int V_FRONT     = 10,
  parameter int V_SYNC      = 2,
  parameter int V_BACK      = 33,
  parameter int IMG_W       = 256,
  parameter int IMG_H       = 256,
  parameter int IMG_X0      = 192,
  parameter int IMG_Y0      = 112,
  parameter int MEM_LATENCY = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        buffer_select,
  input  logic [7:0]  gpu_out,
  output logic        gpu_sel,
  output logic [31:0] gpu_address,
  output logic        hsync,
  output logic        vsync,
  output logic        blank_n,
  output logic [7:0]  red,
  output logic [7:0]  green,
  output logic [7:0]  blue,
  output logic        frame_start
);

  localparam int PAD_W = 32 - CNT_W;

  localparam logic [CNT_W-1:0] ONE_C    = CNT_W'(1);
  localparam logic [CNT_W-1:0] H_LAST_C = CNT_W'(H_VISIBLE + H_FRONT + H_SYNC + H_BACK - 1);
  localparam logic [CNT_W-1:0] V_LAST_C = CNT_W'(V_VISIBLE + V_FRONT + V_SYNC + V_BACK - 1);
  localparam logic [CNT_W-1:0] H_VIS_C  = CNT_W'(H_VISIBLE);
  localparam logic [CNT_W-1:0] V_VIS_C  = CNT_W'(V_VISIBLE);
  localparam logic [CNT_W-1:0] HS_LO_C  = CNT_W'(H_VISIBLE + H_FRONT);
  localparam logic [CNT_W-1:0] HS_HI_C  = CNT_W'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [CNT_W-1:0] VS_LO_C  = CNT_W'(V_VISIBLE + V_FRONT);
  localparam logic [CNT_W-1:0] VS_HI_C  = CNT_W'(V_VISIBLE + V_FRONT + V_SYNC);
  localparam logic [CNT_W-1:0] X0_C     = CNT_W'(IMG_X0);
  localparam logic [CNT_W-1:0] X1_C     = CNT_W'(IMG_X0 + IMG_W);
  localparam logic [CNT_W-1:0] Y0_C     = CNT_W'(IMG_Y0);
  localparam logic [CNT_W-1:0] Y1_C     = CNT_W'(IMG_Y0 + IMG_H);
  localparam logic [31:0]      IMG_W_C  = 32'(IMG_W);

  logic [CNT_W-1:0] hcount_r;
  logic [CNT_W-1:0] vcount_r;
  logic             h_last_s;
  logic             v_last_s;
  logic             visible_s;
  logic             win_s;
  logic [CNT_W-1:0] rel_x_s;
  logic [CNT_W-1:0] rel_y_s;
  logic [31:0]      addr_s;
  scan_ctrl_t       ctrl_s;
  scan_ctrl_t       ctrl_r;
  scan_ctrl_t       ctrl_d_s;
  logic [7:0]       pixel_s;

  assign h_last_s = (hcount_r == H_LAST_C);
  assign v_last_s = (vcount_r == V_LAST_C);

  // Stage 0: free-running pixel/line counters, wrapping at frame end.
  always_ff @(posedge clk) begin
    if (rst) begin
      hcount_r <= '0;
      vcount_r <= '0;
    end else if (h_last_s) begin
      hcount_r <= '0;
      vcount_r <= v_last_s ? '0 : (vcount_r + ONE_C);
    end else begin
      hcount_r <= hcount_r + ONE_C;
      vcount_r <= vcount_r;
    end
  end

  // Decode the current scan position into control flags and image address.
  always_comb begin
    visible_s = (hcount_r < H_VIS_C) && (vcount_r < V_VIS_C);
    win_s     = visible_s && in_range(hcount_r, X0_C, X1_C)
                          && in_range(vcount_r, Y0_C, Y1_C);
    rel_x_s   = hcount_r - X0_C;
    rel_y_s   = vcount_r - Y0_C;
    ctrl_s           = SCAN_IDLE;
    ctrl_s.visible   = visible_s;
    ctrl_s.in_window = win_s;
    ctrl_s.hsync_n   = !in_range(hcount_r, HS_LO_C, HS_HI_C);
    ctrl_s.vsync_n   = !in_range(vcount_r, VS_LO_C, VS_HI_C);
    ctrl_s.first     = (hcount_r == '0) && (vcount_r == '0);
    if (win_s) begin
      addr_s = ({{PAD_W{1'b0}}, rel_y_s} * IMG_W_C) + {{PAD_W{1'b0}}, rel_x_s};
    end else begin
      addr_s = 32'd0;
    end
  end

  // Stage 1: register memory address and control; latch buffer select only
  // at the frame wrap so a frame is always read from a single buffer.
  always_ff @(posedge clk) begin
    if (rst) begin
      gpu_address <= 32'd0;
      ctrl_r      <= SCAN_IDLE;
      gpu_sel     <= 1'b0;
    end else begin
      gpu_address <= addr_s;
      ctrl_r      <= ctrl_s;
      if (h_last_s && v_last_s) begin
        gpu_sel <= buffer_select;
      end else begin
        gpu_sel <= gpu_sel;
      end
    end
  end

  scan_delay #(
    .DEPTH (MEM_LATENCY)
  ) u_scan_delay (
    .clk  (clk),
    .clr  (rst),
    .din  (ctrl_r),
    .dout (ctrl_d_s)
  );

  // Select the memory byte inside the image window, black elsewhere.
  always_comb begin
    if (ctrl_d_s.in_window) begin
      pixel_s = gpu_out;
    end else begin
      pixel_s = 8'h00;
    end
  end

  // Output stage: register colour, syncs and flags together.
  always_ff @(posedge clk) begin
    if (rst) begin
      red         <= 8'h00;
      green       <= 8'h00;
      blue        <= 8'h00;
      hsync       <= 1'b1;
      vsync       <= 1'b1;
      blank_n     <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      red         <= pixel_s;
      green       <= pixel_s;
      blue        <= pixel_s;
      hsync       <= ctrl_d_s.hsync_n;
      vsync       <= ctrl_d_s.vsync_n;
      blank_n     <= ctrl_d_s.visible;
      frame_start <= ctrl_d_s.first;
    end
  end

endmodule
